// File: rtl/vga_pkg.sv
// Package: vga_pkg
// Purpose: Shared constants for the VGA raster generator.
//   - 800x600@72Hz timing (50 MHz pixel clock) and the derived line/frame totals
//   - 3-3-2 RGB colour constants, packed {R[2:0],G[2:0],B[1:0]}
//   - counter width and a small window-compare helper used for sync decoding
package vga_pkg;

   localparam int CNT_W = 11;

   localparam int VGA_H_VIS  = 800;
   localparam int VGA_H_FP   = 56;
   localparam int VGA_H_SYNC = 120;
   localparam int VGA_H_BP   = 64;
   localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_VIS  = 600;
   localparam int VGA_V_FP   = 37;
   localparam int VGA_V_SYNC = 6;
   localparam int VGA_V_BP   = 23;
   localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam logic [7:0] BLACK  = 8'h00;
   localparam logic [7:0] RED    = 8'hE0;
   localparam logic [7:0] YELLOW = 8'hFC;
   localparam logic [7:0] BLUE   = 8'h03;
   localparam logic [7:0] WHITE  = 8'hFF;

   // Half-open window test: lo <= v < hi
   function automatic logic in_window(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Module: vga_sync_delay
// Purpose: PIPE-deep shift register for {video_on, hs_raw, vs_raw}, advancing only
//   on pixel ticks, so blanking and sync line up with the renderer's latency.
//   PIPE = 0 is a straight wire. Reset fills every stage with "blank, sync inactive".
// Ports:
//   clk   in   system clock
//   reset in   synchronous, active-high
//   tick  in   pixel tick enable
//   din   in   3  {video_on, hs_raw, vs_raw} for the current counter position
//   dout  out  3  the same bits delayed by PIPE ticks
module vga_sync_delay #(
   parameter int PIPE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [2:0] din,
   output logic [2:0] dout
);

   generate
      if (PIPE == 0) begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, reset, tick};
         assign dout = din;
      end else begin : g_pipe
         logic [2:0] stage_q [PIPE];
         logic [2:0] stage_d [PIPE];

         always_comb begin
            for (int i = 0; i < PIPE; i++) begin
               stage_d[i] = stage_q[i];
            end
            if (tick) begin
               stage_d[0] = din;
               for (int i = 1; i < PIPE; i++) begin
                  stage_d[i] = stage_q[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < PIPE; i++) begin
                  stage_q[i] <= 3'b000;
               end
            end else begin
               for (int i = 0; i < PIPE; i++) begin
                  stage_q[i] <= stage_d[i];
               end
            end
         end

         assign dout = stage_q[PIPE-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Module: vga_timing_gen
// Purpose: 800x600@72Hz VGA raster timing. Drives pixel_x/pixel_y to the renderer,
//   takes its registered 3-3-2 RGB back, delays blank/sync by the renderer latency
//   and registers the board-level RGB and sync outputs.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   pixel_x, pixel_y   11-bit column / line counters
//   pix_tick           one-clk strobe; counters advance on this cycle
//   video_on           undelayed visible-area flag
//   frame_start        high in the clk whose edge loads counters with (0,0)
//   rgb_in             {R[2:0],G[2:0],B[1:0]} from renderer, sampled on pix_tick
//   vga_r/g/b          registered, blanked RGB
//   hsync, vsync       registered syncs, polarity per SYNC_POL
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int H_VIS    = VGA_H_VIS,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_VIS    = VGA_V_VIS,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int SYNC_POL = 1,
   parameter int PIPE     = 1
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             pix_tick,
   output logic             video_on,
   output logic             frame_start,
   input  logic [7:0]       rgb_in,
   output logic [2:0]       vga_r,
   output logic [2:0]       vga_g,
   output logic [1:0]       vga_b,
   output logic             hsync,
   output logic             vsync
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_totals
         $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 11 bits");
      end
      if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
         $error("vga_timing_gen: CLK_DIV must be 1..16");
      end
      if (PIPE < 0 || PIPE > 4) begin : g_bad_pipe
         $error("vga_timing_gen: PIPE must be 0..4");
      end
   endgenerate

   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
   localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);
   localparam logic             POL      = (SYNC_POL != 0);

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] hcount_q, hcount_d;
   logic [CNT_W-1:0] vcount_q, vcount_d;
   logic [7:0]       rgb_q, rgb_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;

   logic             tick;
   logic             hs_raw, vs_raw;
   logic [2:0]       dly_out;

   // Gated by reset so no strobe (and hence no frame_start) leaks out while held
   assign tick = !reset && (div_q == DIV_LAST);

   assign hs_raw   = in_window(hcount_q, HS_START, HS_END);
   assign vs_raw   = in_window(vcount_q, VS_START, VS_END);
   assign video_on = (hcount_q < H_VIS_C) && (vcount_q < V_VIS_C);

   always_comb begin
      div_d    = div_q;
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (tick) begin
         div_d = '0;
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
         end else begin
            hcount_d = hcount_q + CNT_W'(1);
         end
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // ---- renderer-latency delay of {video_on, hs_raw, vs_raw} ----
   vga_sync_delay #(
      .PIPE (PIPE)
   ) u_sync_delay (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .din   ({video_on, hs_raw, vs_raw}),
      .dout  (dly_out)
   );

   // ---- output register stage: one more tick after the delay line ----
   always_comb begin
      rgb_d   = rgb_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      if (tick) begin
         rgb_d   = dly_out[2] ? rgb_in : BLACK;
         hsync_d = ~(dly_out[1] ^ POL);
         vsync_d = ~(dly_out[0] ^ POL);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q    <= '0;
         hcount_q <= '0;
         vcount_q <= '0;
         rgb_q    <= BLACK;
         hsync_q  <= ~POL;
         vsync_q  <= ~POL;
      end else begin
         div_q    <= div_d;
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         rgb_q    <= rgb_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
      end
   end

   assign pix_tick    = tick;
   assign frame_start = tick && (hcount_q == H_LAST) && (vcount_q == V_LAST);
   assign pixel_x     = hcount_q;
   assign pixel_y     = vcount_q;
   assign vga_r       = rgb_q[7:5];
   assign vga_g       = rgb_q[4:2];
   assign vga_b       = rgb_q[1:0];
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 800-pixel horizontal timing with a shortened
// vertical frame (8 lines) so a whole frame fits in a short run.
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int D   = 2;
   localparam int P   = 1;
   localparam int POL = 1;
   localparam int HV = 800, HF = 56, HS = 120, HB = 64;
   localparam int VV = 4,   VF = 1,  VS = 2,   VB = 1;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int BUDGET = 20000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rend_mode = 1'b0;
   logic [7:0]  const_rgb = RED;
   logic [7:0]  rend_q;
   logic [7:0]  rgb_in;
   logic [10:0] pixel_x, pixel_y;
   logic        pix_tick, video_on, frame_start;
   logic [2:0]  vga_r, vga_g;
   logic [1:0]  vga_b;
   logic        hsync, vsync;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .CLK_DIV (D),  .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_VIS (VV),   .V_FP (VF),  .V_SYNC (VS), .V_BP (VB),
      .SYNC_POL (POL), .PIPE (P)
   ) dut (
      .clk (clk), .reset (reset), .pixel_x (pixel_x), .pixel_y (pixel_y),
      .pix_tick (pix_tick), .video_on (video_on), .frame_start (frame_start),
      .rgb_in (rgb_in), .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
      .hsync (hsync), .vsync (vsync)
   );

   // Renderer model: one-tick registered copy of pixel_x[7:0]
   always @(posedge clk) begin
      if (reset) rend_q <= 8'h00;
      else if (pix_tick) rend_q <= pixel_x[7:0];
   end
   assign rgb_in = rend_mode ? rend_q : const_rgb;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: clocks and ticks elapsed since reset release, plus the
   // rgb_in value seen at the most recent tick.
   int         m_clk = 0;
   int         m_tick = 0;
   logic [7:0] m_rgb = 8'h00;
   bit         m_on = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_clk  <= 0;
         m_tick <= 0;
         m_on   <= 1'b1;
      end else if (m_on) begin
         if (m_clk % D == D - 1) begin
            m_tick <= m_tick + 1;
            m_rgb  <= rgb_in;
         end
         m_clk <= m_clk + 1;
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         int q, qx, qy, hx, vy;
         bit e_tick, hs_a, vs_a;
         logic [7:0] e_rgb;
         e_tick = !reset && (m_clk % D == D - 1);
         hx = m_tick % HT;
         vy = (m_tick / HT) % VT;
         chk("pix_tick", int'(pix_tick), int'(e_tick));
         chk("pixel_x", int'(pixel_x), hx);
         chk("pixel_y", int'(pixel_y), vy);
         chk("video_on", int'(video_on), int'(hx < HV && vy < VV));
         chk("frame_start", int'(frame_start), int'(e_tick && hx == HT - 1 && vy == VT - 1));
         q = m_tick - (P + 1);
         if (q < 0) begin
            e_rgb = 8'h00; hs_a = 1'b0; vs_a = 1'b0;
         end else begin
            qx = q % HT;
            qy = (q / HT) % VT;
            hs_a  = (qx >= HV + HF) && (qx < HV + HF + HS);
            vs_a  = (qy >= VV + VF) && (qy < VV + VF + VS);
            e_rgb = (qx < HV && qy < VV) ? m_rgb : 8'h00;
         end
         chk("vga_rgb", int'({vga_r, vga_g, vga_b}), int'(e_rgb));
         chk("hsync", int'(hsync), hs_a ? POL : 1 - POL);
         chk("vsync", int'(vsync), vs_a ? POL : 1 - POL);
      end
   end

   // Bounded wait for a counter position (optionally on a tick cycle)
   task automatic wait_at(input int x, input int y, input bit need_tick, input string nm);
      int found = 0;
      for (int i = 0; i < BUDGET && found == 0; i++) begin
         @(negedge clk);
         if (pixel_x == 11'(x) && pixel_y == 11'(y) && (!need_tick || pix_tick)) found = 1;
      end
      chk({nm, " reached"}, found, 1);
   endtask

   initial begin
      #(95000 * 10);
      $display("FAIL watchdog: run exceeded cycle limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, found;

      // Reset held for 5 clks: outputs idle, no tick
      repeat (5) @(negedge clk);
      chk("rst pix_tick", int'(pix_tick), 0);
      chk("rst hsync", int'(hsync), 0);
      chk("rst vsync", int'(vsync), 0);
      chk("rst rgb", int'({vga_r, vga_g, vga_b}), 0);
      #1 reset = 1'b0;

      // First tick on the 2nd clk after release, hcount 0 -> 1
      @(negedge clk);
      chk("tick1 strobe", int'(pix_tick), 1);
      chk("tick1 x before", int'(pixel_x), 0);
      @(negedge clk);
      chk("tick1 x after", int'(pixel_x), 1);
      chk("tick1 strobe low", int'(pix_tick), 0);
      chk("early hsync", int'(hsync), 0);

      // hsync rises PIPE+1 ticks after hcount 856, lasts 120 ticks
      found = 0;
      for (int i = 0; i < BUDGET && found == 0; i++) begin
         @(negedge clk);
         if (hsync) found = 1;
      end
      chk("hsync rise seen", found, 1);
      chk("hsync rise x", int'(pixel_x), 858);
      cnt = 0;
      while (hsync && cnt < 5000) begin
         @(negedge clk);
         cnt++;
      end
      chk("hsync width clks", cnt, 240);

      // Line wrap 1039 -> 0, vcount 0 -> 1
      wait_at(HT - 1, 0, 1'b1, "line end");
      @(negedge clk);
      chk("wrap x", int'(pixel_x), 0);
      chk("wrap y", int'(pixel_y), 1);

      // Constant red: visible window only, offset PIPE+1 ticks
      wait_at(1, 1, 1'b0, "x1");
      chk("red at x1 (prev line tail)", int'(vga_r), 0);
      wait_at(2, 1, 1'b0, "x2");
      chk("red at x2 (pixel 0)", int'(vga_r), 7);
      chk("green at x2", int'(vga_g), 0);
      wait_at(801, 1, 1'b0, "x801");
      chk("red at x801 (pixel 799)", int'(vga_r), 7);
      wait_at(802, 1, 1'b0, "x802");
      chk("red at x802 (pixel 800)", int'(vga_r), 0);

      // vsync: active for lines 5..6, rising PIPE+1 ticks into line 5
      found = 0;
      for (int i = 0; i < BUDGET && found == 0; i++) begin
         @(negedge clk);
         if (vsync) found = 1;
      end
      chk("vsync rise seen", found, 1);
      chk("vsync rise y", int'(pixel_y), 5);
      chk("vsync rise x", int'(pixel_x), 2);
      cnt = 0;
      while (vsync && cnt < BUDGET) begin
         @(negedge clk);
         cnt++;
      end
      chk("vsync width clks", cnt, 2 * HT * D);
      wait_at(100, 7, 1'b0, "blank line");
      chk("red in blank line", int'(vga_r), 0);

      // Exactly one frame_start per HT*VT ticks
      cnt = 0;
      for (int i = 0; i < HT * VT * D; i++) begin
         @(negedge clk);
         if (frame_start) begin
            cnt++;
            chk("frame_start at x", int'(pixel_x), HT - 1);
            chk("frame_start at y", int'(pixel_y), VT - 1);
         end
      end
      chk("frame_start count", cnt, 1);

      // Renderer echoing pixel_x: output at pixel k equals k[7:0]
      #1 rend_mode = 1'b1;
      wait_at(0, 1, 1'b0, "render line");
      for (int k = 0; k < 6; k++) begin
         wait_at(k + P + 1, 1, 1'b0, "render px");
         chk("render rgb", int'({vga_r, vga_g, vga_b}), k);
      end
      wait_at(256 + P + 1, 1, 1'b0, "render 256");
      chk("render rgb 256", int'({vga_r, vga_g, vga_b}), 0);
      wait_at(257 + P + 1, 1, 1'b0, "render 257");
      chk("render rgb 257", int'({vga_r, vga_g, vga_b}), 1);
      #1 rend_mode = 1'b0;
      const_rgb = YELLOW;

      // Mid-frame reset at (500,2): one clk of reset
      wait_at(500, 2, 1'b0, "mid reset point");
      #1 reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
      chk("midrst x", int'(pixel_x), 0);
      chk("midrst y", int'(pixel_y), 0);
      chk("midrst rgb", int'({vga_r, vga_g, vga_b}), 0);
      chk("midrst hsync", int'(hsync), 0);
      chk("midrst vsync", int'(vsync), 0);
      chk("midrst frame_start", int'(frame_start), 0);
      @(negedge clk);
      @(negedge clk);
      chk("midrst first tick x", int'(pixel_x), 1);

      // Reset during an active hsync pulse: pulse is dropped, not resumed
      wait_at(900, 0, 1'b0, "in hsync");
      chk("hsync before reset", int'(hsync), 1);
      #1 reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
      chk("hsync after reset", int'(hsync), 0);
      chk("x after reset", int'(pixel_x), 0);
      wait_at(100, 0, 1'b0, "post reset line");
      chk("no partial hsync", int'(hsync), 0);
      chk("yellow visible", int'({vga_r, vga_g, vga_b}), int'(YELLOW));

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
